// File: rtl/seq_arbiter_pkg.sv
// Shared definitions for the seq_arbiter block: FSM state encodings,
// 12 MHz default timing constants and the round-robin winner picker.
package seq_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // 1 ms debounce window and 1 s done-timeout at 12 MHz
  localparam int DEF_CLK_ITER_MAX = 11999;
  localparam int DEF_TIMEOUT_MAX  = 11999999;

  // First set bit of req[n-1:0] scanning upward from ptr, wrapping at n.
  // Vectors are sized for the largest supported requester count (8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seq_arbiter_if.sv
// Button/sequencer handshake bundle for seq_arbiter.
// slave: the arbiter side; master: the board/sequencer side.
interface seq_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] reqInput;
  logic               doneSig;
  logic               goOut;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               timeoutSig;

  modport master (
    output reqInput, doneSig,
    input  goOut, grant, busy, timeoutSig
  );

  modport slave (
    input  reqInput, doneSig,
    output goOut, grant, busy, timeoutSig
  );
endinterface

// File: rtl/seq_arbiter_req_debounce.sv
// req_debounce: 2-flop synchroniser, debounce counter and a registered
// rising-edge pulse for one raw push-button input.
module req_debounce #(
  parameter int CLK_ITER_WIDTH = 16,
  parameter int CLK_ITER_MAX   = 11999
) (
  input  logic clk,
  input  logic rstN,
  input  logic raw,
  output logic rise
);

  logic                      sync_p0, sync_p1;
  logic                      deb, deb_d;
  logic                      rise_q;
  logic [CLK_ITER_WIDTH-1:0] cnt;

  // Synchronise, debounce (level flips after CLK_ITER_MAX+1 disagreeing
  // cycles) and register a pulse on each debounced rising edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      rise_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 == deb) begin
        cnt <= '0;
      end else if (cnt == CLK_ITER_WIDTH'(CLK_ITER_MAX)) begin
        deb <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      deb_d  <= deb;
      rise_q <= deb & ~deb_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/seq_arbiter.sv
// seq_arbiter: round-robin sharing of one LED sequencer between NUM_REQ
// debounced push buttons. Optional WAIT timeout: define
// SEQ_ARBITER_TIMEOUT_EN to enable it (default build has no timeout).
module seq_arbiter
  import seq_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CLK_ITER_WIDTH = 16,
  parameter int CLK_ITER_MAX   = DEF_CLK_ITER_MAX,
  parameter int TIMEOUT_WIDTH  = 24,
  parameter int TIMEOUT_MAX    = DEF_TIMEOUT_MAX
) (
  input  logic          clk,
  input  logic          rstN,
  seq_arbiter_if.slave  bus
);

  arb_state_t         state, state_nxt;
  logic [2:0]         owner, owner_nxt;
  logic [2:0]         ptr, ptr_nxt;
  logic [NUM_REQ-1:0] pending, clr, rise, owner_oh;
  logic               tmo_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_deb
    req_debounce #(
      .CLK_ITER_WIDTH (CLK_ITER_WIDTH),
      .CLK_ITER_MAX   (CLK_ITER_MAX)
    ) u_deb (
      .clk  (clk),
      .rstN (rstN),
      .raw  (bus.reqInput[i]),
      .rise (rise[i])
    );
  end

`ifdef SEQ_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

  // Count cycles spent in WAIT, starting from 0 on entry.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                tmo_cnt <= '0;
    else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    else                      tmo_cnt <= '0;
  end

  // doneSig in the terminal cycle wins over the abort.
  assign tmo_hit = (state == ST_WAIT) && !bus.doneSig &&
                   (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_MAX));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{TIMEOUT_WIDTH, TIMEOUT_MAX};
  assign tmo_hit        = 1'b0;
`endif

  // One-hot decode of the current owner index.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner == 3'(i));
  end

  // Next state, winner selection, pointer advance and pending clear.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    clr       = '0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          owner_nxt = rr_pick(8'(pending), ptr, NUM_REQ);
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        clr       = owner_oh;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.doneSig || tmo_hit) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        ptr_nxt   = (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, owner, pointer and pending registers; a new press on the owner
  // during its GRANT cycle survives the clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= ST_IDLE;
      owner   <= 3'd0;
      ptr     <= 3'd0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      pending <= (pending & ~clr) | rise;
    end
  end

  assign bus.goOut      = (state == ST_GRANT);
  assign bus.grant      = (state == ST_IDLE) ? '0 : owner_oh;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.timeoutSig = tmo_hit;

endmodule
